uart_tx_frame: RTL
==================

# uart_tx_frame

Frame builder and serializer for the UART transmit path, directly downstream of `parity_calc`. It accepts a parallel byte on a `DATA_VALID` strobe and consumes the registered `par_bit` produced by `parity_calc` for that same byte. It then drives a start bit, the data bits LSB-first, an optional parity bit and a stop bit onto `TX_OUT`, one bit per `CLK` cycle. `CLK` is the bit (baud) clock; `DATA_VALID` and `P_DATA` are shared with `parity_calc`.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK` in 1: bit clock; all state changes on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `P_DATA` in `DATA_WIDTH`: parallel data, sampled on accept.
- `DATA_VALID` in 1: single-cycle request to send `P_DATA`.
- `PAR_EN` in 1: 1 inserts a parity bit; sampled on accept.
- `par_bit` in 1: parity from `parity_calc`, registered by it on the accept edge.
- `TX_OUT` out 1: serial line, registered, idles high.
- `Busy` out 1: registered, high for every cycle of a frame.

## Operation
- States:
  - `IDLE`: `TX_OUT`=1, `Busy`=0.
  - `START`: `TX_OUT`=0.
  - `DATA`: `TX_OUT`=`data_q[bit_cnt]`.
  - `PARITY`: `TX_OUT`=`par_q`.
  - `STOP`: `TX_OUT`=1.
- Accept occurs when `DATA_VALID`=1 in `IDLE` or in `STOP`. On accept:
  - `data_q` ← `P_DATA` and `par_en_q` ← `PAR_EN`.
  - `bit_cnt` ← 0 and next state is `START`.
- `START`: on the edge ending this cycle, `par_q` ← `par_bit`. This is the first edge at which `parity_calc` output reflects the accepted byte. Next state is `DATA`.
- `DATA`: `bit_cnt` increments each cycle. After bit `DATA_WIDTH-1`:
  - next state is `PARITY` if `par_en_q`=1;
  - otherwise next state is `STOP`.
- `PARITY`: lasts one cycle, then `STOP`.
- `STOP`: lasts one cycle. Next state is `START` on accept, otherwise `IDLE`.
- `DATA_VALID` in `START`, `DATA` or `PARITY` is ignored. The byte is dropped, there is no buffering, and `data_q`, `par_en_q` and `par_q` are unchanged. The upstream side must not strobe while `Busy`=1, except during the stop cycle.
- `bit_cnt` width is `$clog2(DATA_WIDTH)`. It never wraps mid-frame because the exit condition is checked at `DATA_WIDTH-1`.
- `P_DATA`, `PAR_EN` and `par_bit` changes after their sample points do not affect the frame in flight.

## Timing
- Reset: at the first rising edge with `RST`=1, the block goes to `IDLE` with `TX_OUT`=1, `Busy`=0, `bit_cnt`=0, `data_q`=0, `par_q`=0, `par_en_q`=0. This applies from any state, including mid-frame; the partial frame is abandoned and no stop bit is sent. `RST` has priority over `DATA_VALID`.
- Accept at edge k:
  - `TX_OUT`=0 and `Busy`=1 from edge k to edge k+1.
  - Data bit i is driven on cycle k+1+i.
- Frame length is `DATA_WIDTH`+3 cycles with parity and `DATA_WIDTH`+2 without (11 or 10 for the default).
- `Busy` rises at edge k and falls at the edge that ends the stop cycle, unless a back-to-back accept occurs.
- Back-to-back: with `DATA_VALID` in `STOP` at edge s, `TX_OUT` goes from 1 to 0 at edge s with no idle cycle and `Busy` stays 1.
- `par_bit` must be stable from edge k to edge k+1. `parity_calc` guarantees this when no second `DATA_VALID` occurs in between.

## Test plan
- Reset mid-frame: assert `RST` during `DATA` bit 3 → next edge `TX_OUT`=1, `Busy`=0. Release `RST`, then hold `DATA_VALID`=0 for 5 cycles → line stays 1.
- Even parity: `P_DATA`=8'hD2, `PAR_EN`=1, even `parity_calc` (`par_bit`=0) → `TX_OUT` over 11 cycles = 0, 0,1,0,0,1,0,1,1, 0, 1; `Busy` high for exactly those 11 cycles.
- Odd parity: `P_DATA`=8'hD3, `PAR_EN`=1, odd parity (`par_bit`=0) → 0, 1,1,0,0,1,0,1,1, 0, 1.
- Odd parity: `P_DATA`=8'hD2, `PAR_EN`=1, odd parity (`par_bit`=1) → 0, 0,1,0,0,1,0,1,1, 1, 1.
- No parity: `P_DATA`=8'hA5, `PAR_EN`=0 → 10-cycle frame 0, 1,0,1,0,0,1,0,1, 1.
- Back-to-back: strobe 8'h0F with `PAR_EN`=0, then strobe 8'hF0 in its stop cycle → stop 1 is immediately followed by start 0; `Busy` stays continuously high for 20 cycles. A strobe with 8'hFF during `DATA` of the second frame leaves its bits unchanged.

Source files
------------

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmit frame builder and serializer. It accepts a parallel word on a
// single-cycle DATA_VALID strobe and emits, one bit per CLK (bit clock) cycle:
//   start (0), data bits LSB-first, optional parity bit, stop (1).
// The parity bit is not computed here. It is taken from the upstream parity
// calculator, which registers it on the same edge that accepts the word, so
// it is captured one cycle later, at the end of the START cycle.
//
// Ports
//   CLK        in   bit clock, rising-edge active
//   RST        in   synchronous, active-high reset
//   P_DATA     in   parallel data word, sampled on accept
//   DATA_VALID in   single-cycle send request
//   PAR_EN     in   1 = insert parity bit, sampled on accept
//   par_bit    in   parity bit from the upstream parity calculator
//   TX_OUT     out  registered serial line, idles high
//   Busy       out  registered, high for every cycle of a frame
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_r;
  logic                  par_en_r;
  logic                  tx_out_r;
  logic                  busy_r;

  logic                  accept_s;
  logic [CNT_W-1:0]      cnt_next_s;

  // A new word is taken only when idle or during the stop cycle; strobes
  // mid-frame are dropped without touching the captured word.
  assign accept_s   = DATA_VALID && ((state_r == ST_IDLE) || (state_r == ST_STOP));
  assign cnt_next_s = bit_cnt_r + CNT_W'(1);

  // Frame FSM. TX_OUT/Busy are registered with the value belonging to the
  // state being entered, so the line changes on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      data_r    <= '0;
      par_r     <= 1'b0;
      par_en_r  <= 1'b0;
      tx_out_r  <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            data_r    <= P_DATA;
            par_en_r  <= PAR_EN;
            bit_cnt_r <= '0;
            state_r   <= ST_START;
            tx_out_r  <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            tx_out_r  <= 1'b1;
            busy_r    <= 1'b0;
          end
        end

        ST_START: begin
          // Upstream parity for the accepted word is valid from this edge on.
          par_r    <= par_bit;
          state_r  <= ST_DATA;
          tx_out_r <= data_r[0];
          busy_r   <= 1'b1;
        end

        ST_DATA: begin
          busy_r <= 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
            if (par_en_r) begin
              state_r  <= ST_PARITY;
              tx_out_r <= par_r;
            end else begin
              state_r  <= ST_STOP;
              tx_out_r <= 1'b1;
            end
          end else begin
            bit_cnt_r <= cnt_next_s;
            tx_out_r  <= data_r[cnt_next_s];
          end
        end

        ST_PARITY: begin
          state_r  <= ST_STOP;
          tx_out_r <= 1'b1;
          busy_r   <= 1'b1;
        end

        ST_STOP: begin
          if (accept_s) begin
            // Back-to-back: straight into the next start bit, Busy held.
            data_r    <= P_DATA;
            par_en_r  <= PAR_EN;
            bit_cnt_r <= '0;
            state_r   <= ST_START;
            tx_out_r  <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            tx_out_r  <= 1'b1;
            busy_r    <= 1'b0;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= '0;
          tx_out_r  <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_out_r;
  assign Busy   = busy_r;

endmodule
